// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helper for the BCD arithmetic datapath.
package bcd_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned BCD_MAX   = 9;
    localparam int unsigned BCD_RADIX = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/sub_1digit_BCD.sv
// Combinational single-digit BCD subtractor: diff = nr1 - nr2 - borrow_in, wrapped into 0..9.
module sub_1digit_BCD
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] nr1,
    input  logic [DIGIT_W-1:0] nr2,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] diff,
    output logic               borrow_out
);

    logic signed [DIGIT_W:0] t;
    logic signed [DIGIT_W:0] t_wrap;

    always_comb begin
        // Worst case 0 - 9 - 1 = -10 still fits the 5-bit signed range.
        t      = $signed({1'b0, nr1}) - $signed({1'b0, nr2}) - $signed({{DIGIT_W{1'b0}}, borrow_in});
        t_wrap = t + $signed((DIGIT_W + 1)'(BCD_RADIX));
        if (t < 0) begin
            diff       = t_wrap[DIGIT_W-1:0];
            borrow_out = 1'b1;
        end else begin
            diff       = t[DIGIT_W-1:0];
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor A - B, LSB digit first, with start/done handshake.
// Define BCD_SUB_SIGN_MAG_EN to return negative results as magnitude instead of ten's complement.
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] diff,
    output logic                      neg,
    output logic                      err
);

    localparam int unsigned W    = DIGIT_W * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      diff_q, diff_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;

    logic [DIGIT_W-1:0] cur_a, cur_b, cur_diff;
    logic [DIGIT_W-1:0] nr1, nr2, sub_diff;
    logic               sub_bout;
    logic [W-1:0]       diff_wr;
    logic               bad_digit;

    always_comb begin
        cur_a     = '0;
        cur_b     = '0;
        cur_diff  = '0;
        diff_wr   = diff_q;
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_a    = a_q[i*DIGIT_W +: DIGIT_W];
                cur_b    = b_q[i*DIGIT_W +: DIGIT_W];
                cur_diff = diff_q[i*DIGIT_W +: DIGIT_W];
                diff_wr[i*DIGIT_W +: DIGIT_W] = sub_diff;
            end
            if (!digit_valid(a[i*DIGIT_W +: DIGIT_W]) || !digit_valid(b[i*DIGIT_W +: DIGIT_W])) begin
                bad_digit = 1'b1;
            end
        end
    end

    // FIX reuses the same subtractor to form 0 - diff, i.e. the ten's complement.
    assign nr1 = (state_q == StFix) ? '0 : cur_a;
    assign nr2 = (state_q == StFix) ? cur_diff : cur_b;

    sub_1digit_BCD u_sub (
        .nr1        (nr1),
        .nr2        (nr2),
        .borrow_in  (borrow_q),
        .diff       (sub_diff),
        .borrow_out (sub_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        neg_d    = neg_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    diff_d   = '0;
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StSub;
                    end
                end
            end
            StSub: begin
                diff_d   = diff_wr;
                borrow_d = sub_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    neg_d    = sub_bout;
                    idx_d    = '0;
                    borrow_d = 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
                    state_d  = sub_bout ? StFix : StDone;
`else
                    state_d  = StDone;
`endif
                end
            end
            StFix: begin
                diff_d   = diff_wr;
                borrow_d = sub_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign busy = (state_q == StSub) || (state_q == StFix);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial (DIGITS=4): directed table, corner sequences, random ops.
module tb_bcd_sub_serial;

`ifdef BCD_SUB_SIGN_MAG_EN
    localparam bit SignMag = 1'b1;
`else
    localparam bit SignMag = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done, neg, err;
    logic [15:0] diff;

    int checks = 0;
    int errors = 0;

    bcd_sub_serial #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] xdiff;
        logic        xneg;
        logic        xerr;
        int          xlat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Reference: plain integer subtraction on the decoded operands.
    task automatic model(input logic [15:0] ai, input logic [15:0] bi, output logic [15:0] xd,
                         output logic xn, output logic xe, output int xl);
        int d;
        if (has_bad(ai) || has_bad(bi)) begin
            xd = '0; xn = 1'b0; xe = 1'b1; xl = 0;
        end else begin
            d  = bcd2int(ai) - bcd2int(bi);
            xe = 1'b0;
            xn = (d < 0);
            if (SignMag) begin
                xd = int2bcd(d < 0 ? -d : d);
                xl = xn ? 8 : 4;
            end else begin
                xd = int2bcd(d < 0 ? d + 10000 : d);
                xl = 4;
            end
        end
    endtask

    // xlat counts edges after the accepting edge until done is seen.
    task automatic run_op(input string nm, input logic [15:0] ai, input logic [15:0] bi,
                          input logic [15:0] xd, input logic xn, input logic xe, input int xl);
        int lat;
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        check({nm, ":busy_after_start"}, 32'(busy), 32'(!xe));
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, ":done_seen"}, 32'(done), 32'd1);
        check({nm, ":latency"}, 32'(lat), 32'(xl));
        check({nm, ":diff"}, 32'(diff), 32'(xd));
        check({nm, ":neg"}, 32'(neg), 32'(xn));
        check({nm, ":err"}, 32'(err), 32'(xe));
        check({nm, ":busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({nm, ":done_one_cycle"}, 32'(done), 32'd0);
        check({nm, ":diff_held"}, 32'(diff), 32'(xd));
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] ra, rb, xd;
        logic        xn, xe;
        int          xl, lat;

        vecs[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4};
        vecs[1] = '{16'h1234, 16'h5432, SignMag ? 16'h4198 : 16'h5802, 1'b1, 1'b0, SignMag ? 8 : 4};
        vecs[2] = '{16'h0000, 16'h0001, SignMag ? 16'h0001 : 16'h9999, 1'b1, 1'b0, SignMag ? 8 : 4};
        vecs[3] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 4};
        vecs[4] = '{16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1, 0};
        vecs[5] = '{16'h0100, 16'hF000, 16'h0000, 1'b0, 1'b1, 0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:outputs", {12'd0, busy, done, neg, err, diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset:idle", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].xdiff,
                   vecs[i].xneg, vecs[i].xerr, vecs[i].xlat);
        end

        // start re-pulsed while busy must be ignored and not queued
        @(negedge clk);
        a = 16'h5432; b = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("repulse:done_seen", 32'(done), 32'd1);
        check("repulse:diff", 32'(diff), 32'h4198);
        check("repulse:neg", 32'(neg), 32'd0);
        @(posedge clk); #1;
        check("repulse:no_queue", {30'd0, busy, done}, 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        a = 16'h1234; b = 16'h5432; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset:outputs", {12'd0, busy, done, neg, err, diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset:idle", {30'd0, busy, done}, 32'd0);
        run_op("after_reset", 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4);

        for (int n = 0; n < 40; n++) begin
            ra = '0; rb = '0;
            for (int d = 0; d < 4; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) ra[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb = ra;
            model(ra, rb, xd, xn, xe, xl);
            run_op($sformatf("rand%0d_%h_%h", n, ra, rb), ra, rb, xd, xn, xe, xl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
